draw_sequencer: RTL and testbench



---
 rtl/draw_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_draw_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// draw_sequencer: command FIFO plus dispatcher for the fill, circle and
// Reuleaux drawing engines. Commands are queued, popped one at a time into
// the shared job registers, and the matching engine is run with a level
// start / done handshake. The running engine's pixel stream is forwarded to
// the single VGA adapter write port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command offer / FIFO has room
//   cmd_type/colour/x/y/size command fields (type 3 is reserved, dropped)
//   eng_colour/x/y/size      registered job parameters shared by the engines
//   *_start / *_done         per-engine level handshake
//   fill_*/circ_*/reul_*     per-engine pixel outputs
//   vga_x/y/colour/plot      multiplexed adapter write port
//   busy                     queue non-empty or a job in flight
//   jobs_done                completed-job counter (wraps)
//   drop_err                 sticky: a reserved-type command was discarded
module draw_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [2:0] cmd_colour,
    input  logic [7:0] cmd_x,
    input  logic [6:0] cmd_y,
    input  logic [7:0] cmd_size,
    output logic [2:0] eng_colour,
    output logic [7:0] eng_x,
    output logic [6:0] eng_y,
    output logic [7:0] eng_size,
    output logic       fill_start,
    output logic       circ_start,
    output logic       reul_start,
    input  logic       fill_done,
    input  logic       circ_done,
    input  logic       reul_done,
    input  logic [7:0] fill_x,
    input  logic [6:0] fill_y,
    input  logic [2:0] fill_colour,
    input  logic       fill_plot,
    input  logic [7:0] circ_x,
    input  logic [6:0] circ_y,
    input  logic [2:0] circ_colour,
    input  logic       circ_plot,
    input  logic [7:0] reul_x,
    input  logic [6:0] reul_y,
    input  logic [2:0] reul_colour,
    input  logic       reul_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic [7:0] jobs_done,
    output logic       drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [1:0] t;
        logic [2:0] c;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] s;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_RUN, S_RELEASE} state_t;

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_alive;   // holds cmd_ready low until the first edge after reset

    state_t        r_state;
    logic [1:0]    r_type;
    logic          r_first;   // first RUN cycle: done may still be stale
    logic          r_fill_start, r_circ_start, r_reul_start;
    logic [2:0]    r_eng_colour;
    logic [7:0]    r_eng_x, r_eng_size;
    logic [6:0]    r_eng_y;
    logic [7:0]    r_jobs;
    logic          r_drop;

    logic          w_full, w_empty, w_push, w_pop, w_done;
    cmd_t          w_head, w_in;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign cmd_ready = r_alive && !w_full;
    // Ready comes from the registered count, so a pop while full does not
    // open a push slot in the same cycle.
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_head    = r_mem[r_rptr];
    assign w_in      = '{t: cmd_type, c: cmd_colour, x: cmd_x, y: cmd_y, s: cmd_size};

    // Storage needs no reset; pointers and count define the contents.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_done = 1'b0;
        case (r_type)
            2'd0:    w_done = fill_done;
            2'd1:    w_done = circ_done;
            2'd2:    w_done = reul_done;
            default: w_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_type       <= 2'd0;
            r_first      <= 1'b0;
            r_fill_start <= 1'b0;
            r_circ_start <= 1'b0;
            r_reul_start <= 1'b0;
            r_eng_colour <= '0;
            r_eng_x      <= '0;
            r_eng_y      <= '0;
            r_eng_size   <= '0;
            r_jobs       <= '0;
            r_drop       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_type       <= w_head.t;
                        r_eng_colour <= w_head.c;
                        r_eng_x      <= w_head.x;
                        r_eng_y      <= w_head.y;
                        r_eng_size   <= w_head.s;
                        r_state      <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (r_type == 2'd3) begin
                        r_drop  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_fill_start <= (r_type == 2'd0);
                        r_circ_start <= (r_type == 2'd1);
                        r_reul_start <= (r_type == 2'd2);
                        r_first      <= 1'b1;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_first <= 1'b0;
                    if (!r_first && w_done) begin
                        r_fill_start <= 1'b0;
                        r_circ_start <= 1'b0;
                        r_reul_start <= 1'b0;
                        r_state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Start stays low here and through IDLE/DISPATCH, giving
                    // the engine time to drop done before the next job.
                    r_jobs  <= r_jobs + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (r_state == S_RUN) begin
            case (r_type)
                2'd0: begin
                    vga_x = fill_x; vga_y = fill_y; vga_colour = fill_colour; vga_plot = fill_plot;
                end
                2'd1: begin
                    vga_x = circ_x; vga_y = circ_y; vga_colour = circ_colour; vga_plot = circ_plot;
                end
                2'd2: begin
                    vga_x = reul_x; vga_y = reul_y; vga_colour = reul_colour; vga_plot = reul_plot;
                end
                default: ;
            endcase
        end
    end

    assign fill_start = r_fill_start;
    assign circ_start = r_circ_start;
    assign reul_start = r_reul_start;
    assign eng_colour = r_eng_colour;
    assign eng_x      = r_eng_x;
    assign eng_y      = r_eng_y;
    assign eng_size   = r_eng_size;
    assign jobs_done  = r_jobs;
    assign drop_err   = r_drop;
    assign busy       = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: engine models with programmable done latency,
// a scoreboard of expected jobs checked at each start rise, and a cycle
// monitor for the VGA mux, start/done timing and the job counter.
module tb_draw_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_type = '0;
    logic [2:0] cmd_colour = '0;
    logic [7:0] cmd_x = '0;
    logic [6:0] cmd_y = '0;
    logic [7:0] cmd_size = '0;
    logic [2:0] eng_colour;
    logic [7:0] eng_x, eng_size;
    logic [6:0] eng_y;
    logic       fill_start, circ_start, reul_start;
    logic       fill_done, circ_done, reul_done;
    logic [7:0] fill_x, circ_x, reul_x;
    logic [6:0] fill_y, circ_y, reul_y;
    logic [2:0] fill_colour, circ_colour, reul_colour;
    logic       fill_plot, circ_plot, reul_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, drop_err;
    logic [7:0] jobs_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] t;
        logic [2:0] c;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] s;
    } job_t;
    job_t sb[$];

    always #5 clk = ~clk;

    draw_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_colour(cmd_colour), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_size(cmd_size),
        .eng_colour(eng_colour), .eng_x(eng_x), .eng_y(eng_y), .eng_size(eng_size),
        .fill_start(fill_start), .circ_start(circ_start), .reul_start(reul_start),
        .fill_done(fill_done), .circ_done(circ_done), .reul_done(reul_done),
        .fill_x(fill_x), .fill_y(fill_y), .fill_colour(fill_colour), .fill_plot(fill_plot),
        .circ_x(circ_x), .circ_y(circ_y), .circ_colour(circ_colour), .circ_plot(circ_plot),
        .reul_x(reul_x), .reul_y(reul_y), .reul_colour(reul_colour), .reul_plot(reul_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .jobs_done(jobs_done), .drop_err(drop_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Engine models: free-running pixel patterns (distinct per engine, always
    // toggling so a wrongly forwarded engine shows up), done after `delay`
    // start-high cycles unless stalled, optional stale done in the first cycle.
    logic [7:0] fc = '0;
    int         delay = 10;
    bit         stall = 1'b0;
    bit         stale = 1'b0;
    int         cnt[3] = '{0, 0, 0};
    logic [2:0] dr = '0;
    logic [2:0] st_w;

    assign st_w = {reul_start, circ_start, fill_start};
    always @(posedge clk) fc <= fc + 8'd1;
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!st_w[i]) begin
                cnt[i] <= 0;
                dr[i]  <= 1'b0;
            end else begin
                cnt[i] <= cnt[i] + 1;
                if (cnt[i] + 1 >= delay && !stall) dr[i] <= 1'b1;
            end
        end
    end

    assign fill_done   = dr[0] | (stale && fill_start && cnt[0] == 0);
    assign circ_done   = dr[1] | (stale && circ_start && cnt[1] == 0);
    assign reul_done   = dr[2] | (stale && reul_start && cnt[2] == 0);
    assign fill_x      = fc;
    assign fill_y      = fc[6:0] ^ 7'h11;
    assign fill_colour = 3'd1;
    assign fill_plot   = fc[0];
    assign circ_x      = fc + 8'h40;
    assign circ_y      = fc[6:0] ^ 7'h22;
    assign circ_colour = fc[2:0];
    assign circ_plot   = fc[1];
    assign reul_x      = ~fc;
    assign reul_y      = fc[6:0] + 7'd5;
    assign reul_colour = 3'd6;
    assign reul_plot   = fc[0] ^ fc[2];

    // Cycle monitor, sampled on the falling edge.
    logic [2:0]  prev_st = '0;
    int          run_len = 0, prev_run = 0, cyc = 0, last_fall = -100;
    logic        prev_done = 1'b0, pend = 1'b0;
    logic [7:0]  exp_jobs = '0;
    logic [18:0] ev;
    job_t        ej;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_st = '0; run_len = 0; prev_run = 0; prev_done = 1'b0;
            pend = 1'b0; exp_jobs = '0; last_fall = -100;
        end else begin
            chk("start_onehot", 32'($countones(st_w) <= 1), 32'd1);
            case (st_w)
                3'b001:  ev = {fill_plot, fill_x, fill_y, fill_colour};
                3'b010:  ev = {circ_plot, circ_x, circ_y, circ_colour};
                3'b100:  ev = {reul_plot, reul_x, reul_y, reul_colour};
                default: ev = '0;
            endcase
            chk("vga_mux", 32'({vga_plot, vga_x, vga_y, vga_colour}), 32'(ev));
            if (pend) begin
                exp_jobs = exp_jobs + 8'd1;
                pend = 1'b0;
                chk("jobs_inc", 32'(jobs_done), 32'(exp_jobs));
            end
            if (prev_st != 3'b000) begin
                if (prev_run >= 2 && prev_done) chk("start_fall", 32'(st_w), 32'd0);
                else chk("start_hold", 32'(st_w), 32'(prev_st));
            end
            if (prev_st == 3'b000 && st_w != 3'b000) begin
                chk("start_gap", 32'(cyc - last_fall >= 2), 32'd1);
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'(st_w), 32'd0);
                end else begin
                    ej = sb.pop_front();
                    chk("job_type", 32'(st_w), 32'(3'b001 << ej.t));
                    chk("job_colour", 32'(eng_colour), 32'(ej.c));
                    chk("job_x", 32'(eng_x), 32'(ej.x));
                    chk("job_y", 32'(eng_y), 32'(ej.y));
                    if (ej.t != 2'd0) chk("job_size", 32'(eng_size), 32'(ej.s));
                end
                run_len = 1;
            end else if (st_w != 3'b000) begin
                run_len++;
            end
            if (prev_st != 3'b000 && st_w == 3'b000) begin
                chk("jobs_hold", 32'(jobs_done), 32'(exp_jobs));
                pend = 1'b1;
                last_fall = cyc;
                run_len = 0;
            end
            prev_done = |(st_w & {reul_done, circ_done, fill_done});
            prev_st   = st_w;
            prev_run  = run_len;
        end
    end

    task automatic push(input logic [1:0] t, input logic [2:0] c, input logic [7:0] x,
                        input logic [6:0] y, input logic [7:0] s);
        int n = 0;
        job_t j;
        @(negedge clk);
        cmd_type = t; cmd_colour = c; cmd_x = x; cmd_y = y; cmd_size = s;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("push_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (t != 2'd3) begin
                j = '{t: t, c: c, x: x, y: y, s: s};
                sb.push_back(j);
            end
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_jobs(input logic [7:0] n);
        int k = 0;
        while (jobs_done !== n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_jobs", 32'(jobs_done), 32'(n));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_starts", 32'(st_w), 32'd0);
        chk("rst_plot", 32'(vga_plot), 32'd0);
        chk("rst_jobs", 32'(jobs_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);
        chk("rst_eng", 32'({eng_colour, eng_x, eng_y, eng_size}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Single circle, latency check
        delay = 100;
        push(2'd1, 3'd3, 8'd80, 7'd60, 8'd40);
        @(negedge clk);
        chk("lat_t1_start", 32'(circ_start), 32'd0);
        chk("lat_t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("lat_t2_start", 32'(circ_start), 32'd0);
        @(negedge clk);
        chk("lat_t3_start", 32'(circ_start), 32'd1);
        chk("circ_eng", 32'({eng_x, eng_y, eng_size}), 32'({8'd80, 7'd60, 8'd40}));
        wait_jobs(8'd1);
        @(negedge clk);
        chk("circ_idle_busy", 32'(busy), 32'd0);

        // Ordering: fill, reuleaux, circle
        delay = 20;
        push(2'd0, 3'd7, 8'd0, 7'd0, 8'd0);
        push(2'd2, 3'd2, 8'd100, 7'd50, 8'd30);
        push(2'd1, 3'd4, 8'd20, 7'd10, 8'd5);
        wait_jobs(8'd4);

        // Backpressure with a stalled engine
        stall = 1'b1;
        for (int i = 0; i < 5; i++) push(2'd1, 3'(i), 8'(10 + i), 7'(i), 8'(i + 1));
        @(negedge clk);
        chk("bp_ready_full", 32'(cmd_ready), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        cmd_type = 2'd2; cmd_colour = 3'd5; cmd_x = 8'd99; cmd_y = 7'd9; cmd_size = 8'd9;
        cmd_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_ready_hold", 32'(cmd_ready), 32'd0);
        end
        chk("bp_jobs_stalled", 32'(jobs_done), 32'd4);
        stall = 1'b0;
        push(2'd2, 3'd5, 8'd99, 7'd9, 8'd9);
        chk("bp_accept_after", 32'(jobs_done), 32'd5);
        wait_jobs(8'd10);

        // Reserved type dropped, following circle runs; stale done ignored
        stale = 1'b1;
        push(2'd3, 3'd1, 8'd1, 7'd1, 8'd1);
        push(2'd1, 3'd6, 8'd70, 7'd35, 8'd12);
        repeat (3) @(negedge clk);
        chk("drop_set", 32'(drop_err), 32'd1);
        wait_jobs(8'd11);
        repeat (5) @(negedge clk);
        chk("drop_sticky", 32'(drop_err), 32'd1);
        chk("drop_jobs", 32'(jobs_done), 32'd11);
        stale = 1'b0;

        // Reset in the middle of a Reuleaux job with two queued commands
        stall = 1'b1;
        push(2'd2, 3'd5, 8'd33, 7'd44, 8'd66);
        for (int k = 0; k < 20 && !reul_start; k++) @(negedge clk);
        chk("mid_reul_up", 32'(reul_start), 32'd1);
        push(2'd1, 3'd1, 8'd2, 7'd3, 8'd4);
        push(2'd0, 3'd2, 8'd5, 7'd6, 8'd7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_start", 32'(reul_start), 32'd0);
        chk("mid_rst_jobs", 32'(jobs_done), 32'd0);
        chk("mid_rst_drop", 32'(drop_err), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        chk("mid_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        chk("mid_no_starts", 32'(st_w), 32'd0);
        chk("mid_jobs_end", 32'(jobs_done), 32'd0);
        chk("mid_busy_end", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
